// File: rtl/pio_cmd_pkg.sv
// Shared definitions for the PIO command sequencer: word field positions,
// status bit positions, the local CLEAR opcode and the issue FSM encoding.
package pio_cmd_pkg;

  localparam int CMD_TOGGLE = 11;
  localparam int CMD_OP_HI  = 10;
  localparam int CMD_OP_LO  = 8;
  localparam int CMD_ARG_HI = 7;
  localparam int CMD_ARG_LO = 0;

  // FIFO entries hold {opcode, argument}
  localparam int ENTRY_W = 11;

  localparam int ST_OVERFLOW = 11;
  localparam int ST_TIMEOUT  = 10;
  localparam int ST_BUSY     = 9;
  localparam int ST_LEVEL_HI = 8;
  localparam int ST_LEVEL_LO = 6;
  localparam int ST_DONE_HI  = 5;
  localparam int ST_DONE_LO  = 0;

  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pio_cmd_fifo.sv
// Synchronous show-ahead FIFO for queued host commands. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module pio_cmd_fifo
  import pio_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pio_cmd_sequencer.sv
// Turns toggle-flagged host PIO writes into queued, handshaked coprocessor
// commands and exports a registered status word for the host to poll.
module pio_cmd_sequencer
  import pio_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pio_cmd,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_arg,
  input  logic        cmd_ready,
  input  logic        op_done,
  output logic [11:0] status
);

  localparam int          LW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  state_t              state_q;
  state_t              state_next;
  logic                toggle_q;
  logic                new_cmd;
  logic                is_clear;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LW-1:0]       level;
  logic [15:0]         timer_q;
  logic                overflow_q;
  logic                timeout_q;
  logic                busy_q;
  logic [5:0]          done_cnt_q;
  logic                done_evt;
  logic                timeout_evt;

  assign new_cmd  = (pio_cmd[CMD_TOGGLE] != toggle_q);
  assign is_clear = new_cmd && (pio_cmd[CMD_OP_HI:CMD_OP_LO] == OP_CLEAR);
  assign push     = new_cmd && !is_clear;

  pio_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (pio_cmd[CMD_OP_HI:CMD_ARG_LO]),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next  = state_q;
    pop         = 1'b0;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Completion outranks an expiry landing in the same cycle
        if (op_done) begin
          done_evt   = 1'b1;
          state_next = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_evt = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q   <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_arg    <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      toggle_q <= pio_cmd[CMD_TOGGLE];
      busy_q   <= (state_next != IDLE);

      if (pop) begin
        cmd_valid <= 1'b1;
        cmd_op    <= head[CMD_OP_HI:CMD_OP_LO];
        cmd_arg   <= head[CMD_ARG_HI:CMD_ARG_LO];
      end else if (state_q == ISSUE && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      if (state_q == WAIT_DONE) timer_q <= timer_q + 16'd1;
      else                      timer_q <= '0;

      // CLEAR takes priority over any flag event in the same cycle
      if (is_clear)                          overflow_q <= 1'b0;
      else if (push && fifo_full && !pop)    overflow_q <= 1'b1;

      if (is_clear)         timeout_q <= 1'b0;
      else if (timeout_evt) timeout_q <= 1'b1;

      if (is_clear)      done_cnt_q <= '0;
      else if (done_evt) done_cnt_q <= done_cnt_q + 6'd1;
    end
  end

  assign status = {overflow_q, timeout_q, busy_q, 3'(level), done_cnt_q};

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Directed bench for pio_cmd_sequencer with hand-computed status/command values.
module tb_pio_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pio_cmd;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_arg;
  logic        cmd_ready;
  logic        op_done;
  logic [11:0] status;

  int   n_checks = 0;
  int   n_errors = 0;
  logic tog = 1'b0;

  pio_cmd_sequencer #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pio_cmd   (pio_cmd),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_ready (cmd_ready),
    .op_done   (op_done),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    tog     = ~tog;
    pio_cmd = {tog, op, arg};
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    pio_cmd   = 12'h000;
    cmd_ready = 1'b0;
    op_done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_status", status, 12'h000);
    check("rst_valid", {11'd0, cmd_valid}, 12'd0);
    check("rst_op_arg", {1'b0, cmd_op, cmd_arg}, 12'h000);

    // Single command, latency and completion
    cmd_ready = 1'b1;
    send(3'd0, 8'h2A);
    check("t1_valid_k", {11'd0, cmd_valid}, 12'd0);
    check("t1_level_k", status, 12'h040);
    tick();
    check("t1_valid_k1", {11'd0, cmd_valid}, 12'd1);
    check("t1_op_arg", {1'b0, cmd_op, cmd_arg}, 12'h02A);
    check("t1_busy", status, 12'h200);
    tick();
    check("t1_hs_valid", {11'd0, cmd_valid}, 12'd0);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check("t1_done", status, 12'h001);

    // Queueing and overflow with cmd_ready held low
    cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(3'(i), 8'(8'h10 + i));
    check("t2_level4", status, 12'h301);
    check("t2_first", {1'b0, cmd_op, cmd_arg}, 12'h111);
    send(3'd6, 8'h16);
    check("t2_overflow", status, 12'hB01);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("t2_order%0d", i), {cmd_valid, cmd_op, cmd_arg}, {1'b1, 3'(i), 8'(8'h10 + i)});
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      op_done   = 1'b1;
      tick();
      op_done   = 1'b0;
      tick();
    end
    check("t2_drained", {11'd0, cmd_valid}, 12'd0);
    check("t2_status", status, 12'h806);

    // Timeout after exactly 8 cycles in WAIT_DONE
    cmd_ready = 1'b1;
    send(3'd2, 8'h33);
    tick();
    tick();
    repeat (7) tick();
    check("t3_still_busy", status, 12'hA06);
    tick();
    check("t3_timeout", status, 12'hC06);
    cmd_ready = 1'b0;
    op_done   = 1'b1;
    tick();
    op_done   = 1'b0;
    check("t3_late_done", status, 12'hC06);

    // CLEAR with FIFO full and flags set
    for (int i = 1; i <= 6; i++) send(3'(i), 8'(8'h20 + i));
    check("t4_full", status, 12'hF06);
    send(3'd7, 8'h00);
    check("t4_clear", status, 12'h300);
    check("t4_no_clear_issue", {cmd_valid, cmd_op, cmd_arg}, 12'h921);

    // Field change without toggle is ignored
    pio_cmd = {tog, 3'b010, 8'h99};
    tick();
    tick();
    check("t5_no_push", status, 12'h300);
    cmd_ready = 1'b1;
    tick();
    check("t5_in_wait", {11'd0, cmd_valid}, 12'd0);

    // Reset during WAIT_DONE
    reset     = 1'b1;
    pio_cmd   = 12'h000;
    tog       = 1'b0;
    cmd_ready = 1'b0;
    tick();
    reset = 1'b0;
    check("t5_rst_status", status, 12'h000);
    check("t5_rst_cmd", {cmd_valid, cmd_op, cmd_arg}, 12'h000);
    tick();
    check("t5_idle", status, 12'h000);
    cmd_ready = 1'b1;
    send(3'd3, 8'h44);
    tick();
    check("t5_reissue", {cmd_valid, cmd_op, cmd_arg}, 12'hB44);

    // op_done coincides with timer expiry
    tick();
    cmd_ready = 1'b0;
    repeat (7) tick();
    check("t6_busy", status, 12'h200);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check("t6_done_wins", status, 12'h001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
